// File: rtl/bcd_timer_ctrl.sv
// Four-digit BCD timer: start/stop/clear FSM, prescaled count tick, digit ripple, 9999 overflow pulse.
// Optional feature macro BCD_TIMER_STOP_AT_MAX_EN: saturate at 9999 and drop to IDLE instead of wrapping.
module bcd_timer_ctrl #(
  parameter int TICK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic [15:0] bcd_out,
  output logic        running,
  output logic [1:0]  state,
  output logic        ovf
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t        cur_state;
  state_t        nxt_state;
  logic [PW-1:0] presc;
  logic          tick;
  logic          at_max;
  logic          carry;
  logic [15:0]   bcd_next;

  assign at_max = (bcd_out == 16'h9999);
  assign tick   = (cur_state == RUN) && (presc == PMAX) && !clear && !stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    if (clear) begin
      nxt_state = IDLE;
    end else begin
      case (cur_state)
`ifdef BCD_TIMER_STOP_AT_MAX_EN
        IDLE:    if (start && !stop && !at_max) nxt_state = RUN;
        RUN:     if (stop) nxt_state = PAUSE;
                 else if (tick && at_max) nxt_state = IDLE;
`else
        IDLE:    if (start && !stop) nxt_state = RUN;
        RUN:     if (stop) nxt_state = PAUSE;
`endif
        PAUSE:   if (start && !stop) nxt_state = RUN;
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_comb begin
    running = (cur_state == RUN);
    state   = cur_state;
  end

  // Prescaler holds on the stop edge so a pause never loses or gains a RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (cur_state == RUN && !stop) begin
      presc <= (presc == PMAX) ? '0 : presc + PW'(1);
    end
  end

  always_comb begin
    carry    = tick;
    bcd_next = bcd_out;
    for (int k = 0; k < 4; k++) begin
      if (carry)
        bcd_next[4*k +: 4] = (bcd_out[4*k +: 4] == 4'd9) ? 4'd0 : bcd_out[4*k +: 4] + 4'd1;
      carry = carry && (bcd_out[4*k +: 4] == 4'd9);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_out <= 16'h0000;
      ovf     <= 1'b0;
    end else if (clear) begin
      bcd_out <= 16'h0000;
      ovf     <= 1'b0;
    end else begin
      ovf <= tick && at_max;
`ifdef BCD_TIMER_STOP_AT_MAX_EN
      if (tick && !at_max) bcd_out <= bcd_next;
`else
      if (tick) bcd_out <= bcd_next;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Scoreboard bench for bcd_timer_ctrl: one instance at TICK_DIV=4, one at TICK_DIV=1 for ripple/rollover.
module tb_bcd_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, stop0 = 1'b0, clear0 = 1'b0;
  logic        start1 = 1'b0, stop1 = 1'b0, clear1 = 1'b0;
  logic [15:0] bcd0, bcd1;
  logic        run0, run1, ovf0, ovf1;
  logic [1:0]  st0, st1;

  bcd_timer_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start0), .stop(stop0), .clear(clear0),
    .bcd_out(bcd0), .running(run0), .state(st0), .ovf(ovf0)
  );

  bcd_timer_ctrl #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .stop(stop1), .clear(clear1),
    .bcd_out(bcd1), .running(run1), .state(st1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  bit          q_w[$];
  logic [15:0] q_b[$];
  logic [1:0]  q_s[$];
  logic        q_o[$];
  string       q_n[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic push(input bit w, input logic [15:0] b, input logic [1:0] s,
                      input logic o, input string n);
    q_w.push_back(w);
    q_b.push_back(b);
    q_s.push_back(s);
    q_o.push_back(o);
    q_n.push_back(n);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: drain expectations mid-cycle, away from the active edge.
  always @(negedge clk) begin
    while (q_w.size() > 0) begin
      bit          w;
      logic [15:0] eb, ab;
      logic [1:0]  es, as;
      logic        eo, ao, er, ar;
      string       n;
      w  = q_w.pop_front();
      eb = q_b.pop_front();
      es = q_s.pop_front();
      eo = q_o.pop_front();
      n  = q_n.pop_front();
      er = (es == 2'b01);
      ab = w ? bcd1 : bcd0;
      as = w ? st1  : st0;
      ao = w ? ovf1 : ovf0;
      ar = w ? run1 : run0;
      vectors++;
      if (ab !== eb || as !== es || ao !== eo || ar !== er) begin
        miscompares++;
        $display("FAIL %s: got bcd=%h state=%b running=%b ovf=%b, want bcd=%h state=%b running=%b ovf=%b",
                 n, ab, as, ar, ao, eb, es, er, eo);
      end
    end
  end

  initial begin
    push(0, 16'h0000, 2'b00, 1'b0, "reset_dut4");
    push(1, 16'h0000, 2'b00, 1'b0, "reset_dut1");
    step(2);
    reset = 1'b0;

    // First increment lands on the 4th edge after the start edge.
    start0 = 1; step(); start0 = 0;
    push(0, 16'h0000, 2'b01, 1'b0, "start_edge");
    step(3);  push(0, 16'h0000, 2'b01, 1'b0, "before_first_inc");
    step();   push(0, 16'h0001, 2'b01, 1'b0, "first_inc");
    step(35); push(0, 16'h0009, 2'b01, 1'b0, "edge39");
    step();   push(0, 16'h0010, 2'b01, 1'b0, "edge40");

    // Pause after 12 run cycles, then resume.
    clear0 = 1; step(); clear0 = 0;
    push(0, 16'h0000, 2'b00, 1'b0, "clear_run");
    start0 = 1; step(); start0 = 0;
    step(12); push(0, 16'h0003, 2'b01, 1'b0, "run12");
    stop0 = 1; step(); stop0 = 0;
    push(0, 16'h0003, 2'b10, 1'b0, "pause");
    step(20); push(0, 16'h0003, 2'b10, 1'b0, "pause_hold");
    start0 = 1; step(); start0 = 0;
    step(3);  push(0, 16'h0003, 2'b01, 1'b0, "resume_pre");
    step();   push(0, 16'h0004, 2'b01, 1'b0, "resume_inc");

    // Pause mid-window: only the remaining two cycles are needed after resume.
    step(2); stop0 = 1; step(); stop0 = 0;
    step(5);  push(0, 16'h0004, 2'b10, 1'b0, "pause_mid");
    start0 = 1; step(); start0 = 0;
    step();   push(0, 16'h0004, 2'b01, 1'b0, "mid_resume_pre");
    step();   push(0, 16'h0005, 2'b01, 1'b0, "mid_resume_inc");

    // Stop on the edge where the tick would fire.
    step(3); stop0 = 1; step(); stop0 = 0;
    push(0, 16'h0005, 2'b10, 1'b0, "stop_on_tick");
    start0 = 1; step(); start0 = 0;
    push(0, 16'h0005, 2'b01, 1'b0, "stop_tick_resume");
    step();   push(0, 16'h0006, 2'b01, 1'b0, "stop_tick_inc");

    // clear beats stop and start together.
    clear0 = 1; step(); clear0 = 0;
    start0 = 1; step(); start0 = 0;
    step(168); push(0, 16'h0042, 2'b01, 1'b0, "count42");
    clear0 = 1; start0 = 1; stop0 = 1; step();
    clear0 = 0; start0 = 0; stop0 = 0;
    push(0, 16'h0000, 2'b00, 1'b0, "clear_all_cmds");

    // Asynchronous reset mid-cycle.
    start0 = 1; step(); start0 = 0;
    step(228); push(0, 16'h0057, 2'b01, 1'b0, "count57");
    step(2);
    #2 reset = 1'b1;
    #1 push(0, 16'h0000, 2'b00, 1'b0, "async_reset");
    step(); reset = 1'b0;
    step(10); push(0, 16'h0000, 2'b00, 1'b0, "after_reset");

    // TICK_DIV=1: ripple across digits and rollover.
    start1 = 1; step(); start1 = 0;
    step(99);   push(1, 16'h0099, 2'b01, 1'b0, "t99");
    step();     push(1, 16'h0100, 2'b01, 1'b0, "t100");
    step(899);  push(1, 16'h0999, 2'b01, 1'b0, "t999");
    step();     push(1, 16'h1000, 2'b01, 1'b0, "t1000");
    step(8999); push(1, 16'h9999, 2'b01, 1'b0, "t9999");
`ifdef BCD_TIMER_STOP_AT_MAX_EN
    step();     push(1, 16'h9999, 2'b00, 1'b1, "rollover");
    step();     push(1, 16'h9999, 2'b00, 1'b0, "rollover_next");
    start1 = 1; step(); start1 = 0;
    push(1, 16'h9999, 2'b00, 1'b0, "start_at_max_ignored");
`else
    step();     push(1, 16'h0000, 2'b01, 1'b1, "rollover");
    step();     push(1, 16'h0001, 2'b01, 1'b0, "rollover_next");
`endif
    clear1 = 1; step(); clear1 = 0;
    push(1, 16'h0000, 2'b00, 1'b0, "clear_dut1");

    step(2);
    if (q_w.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", q_w.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Four-digit BCD timer controller that sequences a cascade of mod-10 digit counters from start/stop/clear commands. A programmable prescaler converts the system clock into count ticks. The block ripples carries between digits and reports overflow. It sits between the front-panel command logic and the seven-segment display path, replacing hand-wired enable chains between single BCD digit counters.

## Interface
- TICK_DIV, default 4: clock cycles per count tick; legal range 1..65535.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level; run or resume request, sampled each rising edge.
- stop  input  1  level; pause request.
- clear  input  1  level; zero the count and return to IDLE.
- bcd_out  output  16  digits; [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- running  output  1  high while state is RUN.
- state  output  2  IDLE=2'b00, RUN=2'b01, PAUSE=2'b10; 2'b11 never driven.
- ovf  output  1  one-cycle registered pulse on 9999 rollover.

## Operation
- Reset (async, asserted): state=IDLE, bcd_out=16'h0000, prescaler=0, ovf=0, running=0.
- Command priority each edge: clear > stop > start.
- IDLE: start -> RUN with prescaler=0; stop ignored.
- RUN: stop -> PAUSE; start alone ignored.
- PAUSE: start without stop -> RUN, prescaler keeps its value; stop, or stop+start -> stay PAUSE.
- clear, any state: next edge gives state=IDLE, bcd_out=0, prescaler=0, ovf=0.
- Prescaler: width max(1, clog2(TICK_DIV)). In RUN it counts 0..TICK_DIV-1 and wraps. It holds in PAUSE and IDLE.
- tick (internal): state==RUN && prescaler==TICK_DIV-1 && !clear && !stop.
- On tick, digit 0 increments. Digit k increments when tick is high and all lower digits are 9.
- Each digit wraps 9 -> 0. Digit values stay in 0..9 at all times.
- Rollover: tick with bcd_out==16'h9999 -> ovf=1 for exactly one cycle, on the same edge as the wrap.
- Reset asserted mid-count: all outputs return to reset values immediately. The count does not resume after reset releases.

## Timing
- running and state are registered and change on the edge that samples the command; latency 1 edge.
- First increment from IDLE: digits become 0001 on the TICK_DIV-th rising edge after the edge that samples start.
- Steady RUN: one increment every TICK_DIV cycles.
- TICK_DIV=1: increments on every RUN cycle.
- PAUSE then resume: the remaining prescaler cycles are preserved, so total RUN cycles per increment stays exactly TICK_DIV.
- bcd_out and ovf are register outputs with no combinational path from inputs.
- stop sampled on the same edge that tick would fire: no increment; state goes to PAUSE.

## Configuration
- BCD_TIMER_STOP_AT_MAX_EN defined:
  - On a tick at 9999, bcd_out holds 9999, ovf pulses once, and state goes to IDLE (running=0).
  - start from IDLE with bcd_out=9999 is ignored until clear.
- BCD_TIMER_STOP_AT_MAX_EN undefined:
  - Count wraps 9999 -> 0000, ovf pulses, and state stays RUN.

## Test plan
- Reset then start pulse, TICK_DIV=4: bcd_out=0001 at 4th edge after the start edge; 0010 after 40 cycles; running=1, state=01.
- Run 12 cycles, assert stop for 1 cycle, wait 20 cycles, then start: bcd_out=0003 through PAUSE (state=10); next increment exactly 4 RUN cycles after the previous one.
- Preload via run to 0099, TICK_DIV=1: next edge gives 0100; at 0999 the next edge gives 1000 (multi-digit ripple).
- Run to 9999, one more tick, macro undefined: bcd_out=0000, ovf high exactly 1 cycle, state=01. Macro defined: bcd_out=9999, ovf 1 cycle, state=00, subsequent start ignored.
- clear+start+stop asserted together in RUN at count 0042: next edge gives bcd_out=0000, state=00, ovf=0.
- Assert reset asynchronously mid-cycle at count 0057 in RUN: outputs go to 0000/IDLE before the next clock edge; after release, with no start, the count stays 0000.
